// File: rtl/imsic_pkg.sv
// imsic_pkg: MSI word width helpers and sender FSM state encoding shared by the IMSIC MSI send path.
package imsic_pkg;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // Word layout is {hart, intp_file, eid}; a file count of 2+GEILEN covers M, S and the guest files.
    function automatic int msi_info_width(input int nr_harts, input int geilen, input int nr_src);
        return clog2_min1(nr_harts) + clog2_min1(geilen + 2) + clog2_min1(nr_src);
    endfunction
    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} msi_send_st_e;
endpackage

// File: rtl/imsic_msi_send_ctrl_if.sv
// imsic_msi_send_ctrl_if: requester handshake plus the valid/word pair driven toward the csr_clk receiver.
interface imsic_msi_send_ctrl_if #(
    parameter int NR_REQ = 2,
    parameter int W      = 12
);
    logic [NR_REQ-1:0]   i_req_vld;
    logic [NR_REQ*W-1:0] i_req_info;
    logic [NR_REQ-1:0]   o_req_rdy;
    logic [W-1:0]        o_msi_info;
    logic                o_msi_info_vld;
    logic                o_busy;
    modport master (output i_req_vld, i_req_info, input o_req_rdy, o_msi_info, o_msi_info_vld, o_busy);
    modport slave  (input i_req_vld, i_req_info, output o_req_rdy, o_msi_info, o_msi_info_vld, o_busy);
endinterface

// File: rtl/imsic_rr_arb.sv
// imsic_rr_arb: combinational round-robin pick of the first request at/after ptr, wrapping.
module imsic_rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic any;
    // Lowest requester overall is the wrap fallback; lowest at/after ptr overrides it.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                any     = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && IW'(j) >= ptr) gnt_idx = IW'(j);
        end
        gnt = (en && any) ? (N'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/imsic_msi_send_ctrl.sv
// imsic_msi_send_ctrl: grants one MSI requester at a time and emits its word as a fixed-width valid
// pulse followed by a guard gap, holding the word stable for the slower csr_clk receiver.
module imsic_msi_send_ctrl
    import imsic_pkg::*;
#(
    parameter int NR_REQ       = 2,
    parameter int GEILEN       = 5,
    parameter int NR_HARTS     = 1,
    parameter int NR_SRC       = 256,
    parameter int VLD_HIGH_CYC = 4,
    parameter int VLD_LOW_CYC  = 6
) (
    input  logic                       clk,
    input  logic                       rstn,
    imsic_msi_send_ctrl_if.slave       bus
);
    localparam int W    = msi_info_width(NR_HARTS, GEILEN, NR_SRC);
    localparam int IW   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CMAX = (VLD_HIGH_CYC > VLD_LOW_CYC) ? VLD_HIGH_CYC : VLD_LOW_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    if (VLD_HIGH_CYC < 1 || VLD_LOW_CYC < 1 || NR_REQ < 1) begin : g_param_chk
        $error("imsic_msi_send_ctrl: VLD_HIGH_CYC, VLD_LOW_CYC and NR_REQ must be >= 1");
    end

    msi_send_st_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  info_q, info_d;
    logic          vld_q, vld_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [NR_REQ-1:0] gnt;
    logic [IW-1:0] gnt_idx;

    // Granting is suppressed while in reset so rdy reads 0 even though the state is IDLE.
    imsic_rr_arb #(.N(NR_REQ), .IW(IW)) u_arb (
        .req     (bus.i_req_vld),
        .ptr     (ptr_q),
        .en      (state_q == ST_IDLE && rstn),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        info_d  = info_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: if (|gnt) begin
                info_d  = bus.i_req_info[int'(gnt_idx)*W +: W];
                vld_d   = 1'b1;
                cnt_d   = CW'(VLD_HIGH_CYC - 1);
                ptr_d   = (gnt_idx == IW'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                state_d = ST_HIGH;
            end
            ST_HIGH: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                     else begin
                         vld_d   = 1'b0;
                         cnt_d   = CW'(VLD_LOW_CYC - 1);
                         state_d = ST_LOW;
                     end
            ST_LOW:  if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                     else state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            info_q  <= '0;
            vld_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            info_q  <= info_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_req_rdy      = gnt;
    assign bus.o_msi_info     = info_q;
    assign bus.o_msi_info_vld = vld_q;
    assign bus.o_busy         = (state_q != ST_IDLE);
endmodule
